// File: rtl/posit_defines_es3.sv
// posit_defines_es3: shared es3 posit constants and reduction sequencer state type.
package posit_defines_es3;
  localparam int NBITS = 8;
  localparam logic [NBITS-1:0] POSIT_NAR = 8'h80;
  typedef enum logic [1:0] {FLUSH, RUN, DRAIN, OUT} reduce_state_t;
endpackage

// File: rtl/posit_reduce_pair_sel.sv
// posit_reduce_pair_sel: pairs adder results, inputs and the pending operand into issues.
module posit_reduce_pair_sel (
  input  logic        run,
  input  logic        r_valid,
  input  logic [31:0] r_data,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        pend_valid,
  input  logic [31:0] pend_data,
  output logic        in_ready,
  output logic        issue,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        pend_valid_nx,
  output logic [31:0] pend_data_nx
);
  logic acc;
  always_comb begin
    in_ready = run & ~(r_valid & pend_valid);
    acc = i_valid & in_ready;
    issue = (r_valid | acc) & (pend_valid | (r_valid & acc));
    op1 = pend_valid ? pend_data : r_data;
    op2 = acc ? i_data : r_data;
    // a lone source toggles pend occupancy; two sources pair with each other
    pend_valid_nx = (r_valid ^ acc) ? ~pend_valid : pend_valid;
    pend_data_nx = ((r_valid ^ acc) & ~pend_valid) ? (r_valid ? r_data : i_data) : pend_data;
  end
endmodule

// File: rtl/posit_reduce_es3.sv
// posit_reduce_es3: reduces a posit es3 stream to one sum via a pipelined external adder.
// Define POSIT_REDUCE_COUNT_EN to add the out_count element counter port.
module posit_reduce_es3
  import posit_defines_es3::*;
#(
  parameter int ADD_LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inf,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  output logic        add_start,
  input  logic [31:0] add_result,
  input  logic        add_done,
  input  logic        add_inf
`ifdef POSIT_REDUCE_COUNT_EN
  , output logic [15:0] out_count
`endif
);
  localparam int FW = $clog2(ADD_LATENCY + 1);
  localparam int IW = $clog2(ADD_LATENCY + 2) + 1;
  reduce_state_t state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic pend_valid_q, pend_valid_d, pend_valid_nx;
  logic [31:0] pend_q, pend_d, pend_nx, op1, op2;
  logic out_valid_q, out_valid_d, out_inf_q, out_inf_d, add_start_q, add_start_d;
  logic [31:0] out_data_q, out_data_d, add_in1_q, add_in1_d, add_in2_q, add_in2_d;
  logic r, acc, issue;
  // adder output is meaningless until the unreset pipeline has flushed
  assign r = add_done & (state_q == RUN || state_q == DRAIN);
  assign acc = in_valid & in_ready;
  posit_reduce_pair_sel u_sel (
    .run(state_q == RUN),
    .r_valid(r),
    .r_data(add_result),
    .i_valid(in_valid),
    .i_data(in_data),
    .pend_valid(pend_valid_q),
    .pend_data(pend_q),
    .in_ready(in_ready),
    .issue(issue),
    .op1(op1),
    .op2(op2),
    .pend_valid_nx(pend_valid_nx),
    .pend_data_nx(pend_nx)
  );
  always_comb begin
    state_d = state_q;
    flush_d = '0;
    inflight_d = inflight_q + IW'(issue) - IW'(r);
    pend_valid_d = pend_valid_nx;
    pend_d = pend_nx;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_inf_d = out_inf_q | (r & add_inf) | (acc & (in_data == 32'(POSIT_NAR)));
    add_start_d = issue;
    add_in1_d = issue ? op1 : add_in1_q;
    add_in2_d = issue ? op2 : add_in2_q;
    case (state_q)
      FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == FW'(ADD_LATENCY)) state_d = RUN;
      end
      RUN: if (acc & in_last) state_d = DRAIN;
      DRAIN: if (inflight_q == '0 && !r && !issue) begin
        state_d = OUT;
        out_valid_d = 1'b1;
        out_data_d = pend_q;
        pend_valid_d = 1'b0;
        pend_d = '0;
      end
      OUT: if (out_ready) begin
        state_d = RUN;
        out_valid_d = 1'b0;
        out_inf_d = 1'b0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FLUSH;
      flush_q <= '0;
      inflight_q <= '0;
      pend_valid_q <= 1'b0;
      pend_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_inf_q <= 1'b0;
      add_start_q <= 1'b0;
      add_in1_q <= '0;
      add_in2_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      inflight_q <= inflight_d;
      pend_valid_q <= pend_valid_d;
      pend_q <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_inf_q <= out_inf_d;
      add_start_q <= add_start_d;
      add_in1_q <= add_in1_d;
      add_in2_q <= add_in2_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_inf = out_inf_q;
  assign add_start = add_start_q;
  assign add_in1 = add_in1_q;
  assign add_in2 = add_in2_q;
`ifdef POSIT_REDUCE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (state_q == OUT && out_ready) ? '0 : (acc && cnt_q != 16'hFFFF) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign out_count = cnt_q;
`endif
endmodule

// File: tb/tb_posit_reduce_es3.sv
// tb_posit_reduce_es3: directed bench with a behavioural es3 adder pipeline that has no reset.
module tb_posit_reduce_es3;
  localparam int L = 8;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_inf, add_start, add_done, add_inf;
  logic [31:0] out_data, add_in1, add_in2, add_result;
`ifdef POSIT_REDUCE_COUNT_EN
  logic [15:0] out_count;
`endif
  int n_cmp = 0, n_bad = 0, n_start = 0;
  int cyc, stalls, lat, s0;
  logic [7:0] vec [32];

  posit_reduce_es3 #(.ADD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inf(out_inf), .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_done(add_done), .add_inf(add_inf)
`ifdef POSIT_REDUCE_COUNT_EN
    , .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic real dec(input logic [7:0] p);
    logic [7:0] v;
    int i, m, k, e, x;
    real f, w, s;
    if (p == 8'h00) return 0.0;
    v = p[7] ? -p : p;
    i = 6;
    m = 0;
    while (i >= 0 && v[i] == v[6]) begin m++; i--; end
    k = v[6] ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < 3; j++) begin e = e * 2 + ((i >= 0) ? int'(v[i]) : 0); i--; end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin if (v[i]) f += w; w /= 2.0; i--; end
    x = 8 * k + e;
    s = 1.0;
    for (int j = 0; j < x; j++) s *= 2.0;
    for (int j = 0; j < -x; j++) s /= 2.0;
    return p[7] ? -s * f : s * f;
  endfunction

  function automatic logic [7:0] enc(input real x);
    logic [7:0] best = 8'h00;
    real bd = 1.0e300, d;
    for (int c = 0; c < 256; c++) if (c != 128) begin
      d = dec(8'(c)) - x;
      if (d < 0.0) d = -d;
      if (d < bd) begin bd = d; best = 8'(c); end
    end
    return best;
  endfunction

  function automatic logic [7:0] padd(input logic [7:0] a, input logic [7:0] b);
    return (a == 8'h80 || b == 8'h80) ? 8'h80 : enc(dec(a) + dec(b));
  endfunction

  logic [L-1:0] pv = '0, pi = '0;
  logic [L-1:0][7:0] pd = '0;
  logic [7:0] sum;
  assign sum = add_start ? padd(add_in1[7:0], add_in2[7:0]) : 8'h00;
  always @(posedge clk) begin
    pv <= {pv[L-2:0], add_start};
    pd <= {pd[L-2:0], sum};
    pi <= {pi[L-2:0], add_start && sum == 8'h80};
    if (add_start) n_start <= n_start + 1;
  end
  assign add_done = pv[L-1];
  assign add_result = {24'b0, pd[L-1]};
  assign add_inf = pi[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int n);
    int idx = 0;
    cyc = 0;
    stalls = 0;
    s0 = n_start;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      in_valid = 1;
      in_data = {24'b0, vec[idx]};
      in_last = (idx == n - 1);
      #4;
      cyc++;
      if (in_ready) idx++;
      else stalls++;
    end
    if (idx < n) check("drive_timeout", 32'(idx), 32'(n));
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic collect(input string tag, input logic [7:0] exp_d, input logic exp_i, input int exp_n);
    int k = 0;
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    lat = k + 1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, {24'b0, exp_d});
    check({tag, "_inf"}, 32'(out_inf), 32'(exp_i));
`ifdef POSIT_REDUCE_COUNT_EN
    check({tag, "_count"}, 32'(out_count), 32'(exp_n));
`else
    if (exp_n < 0) check({tag, "_n"}, 32'(exp_n), 32'd0);
`endif
    @(negedge clk);
    check({tag, "_hold"}, {31'b0, out_valid} + out_data, 32'd1 + {24'b0, exp_d});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({tag, "_taken"}, 32'(out_valid), 32'd0);
    check({tag, "_infclr"}, 32'(out_inf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_inf", 32'(out_inf), 32'd0);
    check("rst_start", {31'b0, add_start} | add_in1 | add_in2, 32'd0);
    reset = 0;
    in_valid = 1;
    in_data = 32'h40;
    for (int i = 0; i < 10; i++) begin
      #4;
      check($sformatf("flush_rdy%0d", i), 32'(in_ready), 32'(i >= 9));
      if (i == 9) in_valid = 0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) vec[i] = 8'h40;
    drive(4);
    collect("four", 8'h48, 1'b0, 4);
    check("four_starts", 32'(n_start - s0), 32'd3);
    check("four_inflight", 32'(dut.inflight_q), 32'd0);
    vec[0] = 8'h40;
    drive(1);
    collect("single", 8'h40, 1'b0, 1);
    check("single_lat", 32'(lat), 32'd2);
    check("single_starts", 32'(n_start - s0), 32'd0);
    vec[0] = 8'h40;
    vec[1] = 8'hC0;
    drive(2);
    collect("cancel", 8'h00, 1'b0, 2);
    vec[0] = 8'h40;
    vec[1] = 8'h80;
    vec[2] = 8'h44;
    drive(3);
    collect("nar", 8'h80, 1'b1, 3);
    for (int i = 0; i < 16; i++) vec[i] = 8'h40;
    drive(16);
    check("stress_cycles", 32'(cyc), 32'd20);
    check("stress_stalls", 32'(stalls), 32'd4);
    collect("stress", 8'h50, 1'b0, 16);
    check("stress_starts", 32'(n_start - s0), 32'd15);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_data = 32'h40;
      in_last = 0;
    end
    @(negedge clk);
    in_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #4;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_inflight", 32'(dut.inflight_q), 32'd0);
    vec[0] = 8'h40;
    vec[1] = 8'h44;
    drive(2);
    collect("post_rst", 8'h46, 1'b0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
